// File: rtl/vu_frame_scheduler.sv
// vu_frame_scheduler
// Collects level samples during a video frame and keeps the largest one.
// On each vertical sync edge it commits a new bar level and peak-hold value,
// applying attack/decay ballistics, so the bar only changes between frames.
// Optional build macro: VU_OVERLOAD_EN adds a full-scale overload indicator;
// without it, overload is tied low.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   ACCUM  | accept samples, track the frame maximum, wait for v_sync edge
//   UPDATE | single cycle: commit level/peak/hold, clear frame maximum
module vu_frame_scheduler #(
  parameter int DW          = 8,
  parameter bit V_POL       = 1'b0,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 2
) (
  input  logic          pixel_clock,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_data,
  output logic          sample_ready,
  input  logic          v_sync,
  output logic [DW-1:0] data,
  output logic [DW-1:0] peak,
  output logic          overload
);

  localparam int            HW     = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [DW-1:0] C_STEP = DW'(DECAY_STEP);
  localparam logic [HW-1:0] C_HOLD = HW'(HOLD_FRAMES);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_vs_d;
  logic [DW-1:0] r_acc_max;
  logic [DW-1:0] r_data;
  logic [DW-1:0] r_peak;
  logic [HW-1:0] r_hold_cnt;

  logic          w_frame_evt;
  logic          w_accept;
  logic          w_update;
  logic [DW-1:0] w_data_decay;
  logic [DW-1:0] w_data_nxt;
  logic [DW-1:0] w_peak_decay;
  logic [DW-1:0] w_peak_floor;

  assign w_frame_evt = (v_sync == V_POL) && (r_vs_d != V_POL);
  assign w_accept    = sample_valid && sample_ready;
  assign data        = r_data;
  assign peak        = r_peak;

  // Delayed v_sync for edge detection; resets to the active level so the
  // first cycle after reset can never look like a fresh edge.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) r_vs_d <= V_POL;
    else       r_vs_d <= v_sync;
  end

  // FSM state register.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and control outputs.
  always_comb begin
    w_state_nxt  = r_state;
    sample_ready = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        sample_ready = !reset;
        if (w_frame_evt) w_state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        w_update    = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // Ballistics: instant attack, saturating decay floored at the new frame max;
  // peak decay is floored at the freshly committed level so peak >= data.
  always_comb begin
    w_data_decay = (r_data > C_STEP) ? (r_data - C_STEP) : '0;
    if (r_acc_max >= r_data)
      w_data_nxt = r_acc_max;
    else
      w_data_nxt = (w_data_decay > r_acc_max) ? w_data_decay : r_acc_max;
    w_peak_decay = (r_peak > C_STEP) ? (r_peak - C_STEP) : '0;
    w_peak_floor = (w_peak_decay > w_data_nxt) ? w_peak_decay : w_data_nxt;
  end

  // Running maximum of the samples accepted in the current frame.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset)
      r_acc_max <= '0;
    else if (w_update)
      r_acc_max <= '0;
    else if (w_accept && (sample_data > r_acc_max))
      r_acc_max <= sample_data;
  end

  // Commit displayed level, peak and hold counter once per frame.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_data     <= '0;
      r_peak     <= '0;
      r_hold_cnt <= '0;
    end else if (w_update) begin
      r_data <= w_data_nxt;
      if (r_acc_max >= r_peak) begin
        r_peak     <= r_acc_max;
        r_hold_cnt <= C_HOLD;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - HW'(1);
      end else begin
        r_peak <= w_peak_floor;
      end
    end
  end

`ifdef VU_OVERLOAD_EN
  logic r_ovl_flag;
  logic r_overload;

  assign overload = r_overload;

  // Remember any full-scale sample this frame; publish it for the next frame.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      r_ovl_flag <= 1'b0;
      r_overload <= 1'b0;
    end else if (w_update) begin
      r_overload <= r_ovl_flag;
      r_ovl_flag <= 1'b0;
    end else if (w_accept && (sample_data == {DW{1'b1}})) begin
      r_ovl_flag <= 1'b1;
    end
  end
`else
  assign overload = 1'b0;
`endif

endmodule

// File: tb/tb_vu_frame_scheduler.sv
// Testbench for vu_frame_scheduler: directed test-plan sequence with literal
// expectations, then randomized frames checked against a frame-level model.
module tb_vu_frame_scheduler;

  localparam int DW   = 8;
  localparam int HOLD = 3;
  localparam int STEP = 2;
`ifdef VU_OVERLOAD_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic          pixel_clock = 1'b0;
  logic          reset       = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_data  = '0;
  logic          v_sync       = 1'b1;
  logic          sample_ready;
  logic [DW-1:0] data;
  logic [DW-1:0] peak;
  logic          overload;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 pixel_clock = ~pixel_clock;

  vu_frame_scheduler #(
    .DW(DW), .V_POL(1'b0), .HOLD_FRAMES(HOLD), .DECAY_STEP(STEP)
  ) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .v_sync      (v_sync),
    .data        (data),
    .peak        (peak),
    .overload    (overload)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level view: collect every accepted sample of the frame in a queue;
  // when the frame closes, derive level/peak from the ballistics rules.
  int q[$];
  int m_data, m_peak, m_since;
  bit m_ovl, m_upd, m_vs_prev;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sat_dec(input int x);
    return (x > STEP) ? x - STEP : 0;
  endfunction

  task automatic commit_frame();
    int amax = 0;
    bit full = 1'b0;
    int nd;
    foreach (q[i]) begin
      amax = imax(amax, q[i]);
      if (q[i] == 255) full = 1'b1;
    end
    nd = (amax >= m_data) ? amax : imax(sat_dec(m_data), amax);
    if (amax >= m_peak) begin
      m_peak  = amax;
      m_since = 0;
    end else begin
      if (m_since < 1000) m_since++;
      if (m_since > HOLD) m_peak = imax(sat_dec(m_peak), nd);
    end
    m_data = nd;
    m_ovl  = full && OVL;
    q.delete();
  endtask

  always @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      q.delete();
      m_data = 0; m_peak = 0; m_since = HOLD;
      m_ovl = 1'b0; m_upd = 1'b0; m_vs_prev = 1'b0;
    end else begin
      if (m_upd) begin
        commit_frame();
        m_upd = 1'b0;
      end else begin
        if (sample_valid) q.push_back(int'(sample_data));
        if (v_sync == 1'b0 && m_vs_prev == 1'b1) m_upd = 1'b1;
      end
      m_vs_prev = v_sync;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge pixel_clock) begin
    if (chk_en) begin
      check("cyc_data",     int'(data),         m_data);
      check("cyc_peak",     int'(peak),         m_peak);
      check("cyc_ready",    int'(sample_ready), int'(!reset && !m_upd));
      check("cyc_overload", int'(overload),     int'(m_ovl));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    v_sync = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic accept(input int v);
    sample_valid = 1'b1;
    sample_data  = DW'(v);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic frame();
    v_sync = 1'b0;
    repeat (4) tick();
    v_sync = 1'b1;
    repeat (4) tick();
  endtask

  task automatic expect_lvl(input string name, input int d, input int p);
    check({name, "_data"},  int'(data), d);
    check({name, "_peak"},  int'(peak), p);
    check({name, "_mdata"}, m_data, d);
    check({name, "_mpeak"}, m_peak, p);
  endtask

  initial begin
    int exp_d [4] = '{78, 76, 74, 72};
    int exp_p [4] = '{80, 80, 80, 78};
    #1 reset = 1'b1;
    #1 chk_en = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // 1: idle
    repeat (100) tick();
    expect_lvl("idle", 0, 0);
    check("idle_ready", int'(sample_ready), 1);

    // 2: first frame with samples
    accept(10); accept(80); accept(40);
    v_sync = 1'b0;
    tick();
    check("upd_ready_low", int'(sample_ready), 0);
    check("upd_data_old",  int'(data), 0);
    tick();
    check("upd_ready_back", int'(sample_ready), 1);
    expect_lvl("frame1", 80, 80);
    repeat (2) tick();
    v_sync = 1'b1;
    repeat (4) tick();

    // 3: hold then decay
    for (int i = 0; i < 4; i++) begin
      frame();
      expect_lvl($sformatf("decay%0d", i), exp_d[i], exp_p[i]);
    end

    // 4: no wrap below zero
    do_reset();
    accept(1);
    frame();
    expect_lvl("low1", 1, 1);
    frame();
    expect_lvl("low2", 0, 1);
    frame();
    expect_lvl("low3", 0, 1);

    // 5: sample on the edge cycle, sample held through UPDATE
    do_reset();
    v_sync = 1'b0;
    sample_valid = 1'b1;
    sample_data = 8'd200;
    tick();
    sample_data = 8'd50;
    check("edge_ready_low", int'(sample_ready), 0);
    tick();
    check("edge_ready_back", int'(sample_ready), 1);
    expect_lvl("edge", 200, 200);
    tick();
    sample_valid = 1'b0;
    v_sync = 1'b1;
    repeat (4) tick();
    frame();
    expect_lvl("after_edge", 198, 200);
    accept(255);
    frame();
    expect_lvl("full", 255, 255);
    check("ovl_set", int'(overload), int'(OVL));
    frame();
    check("ovl_clear", int'(overload), 0);
    check("ovl_data", int'(data), 253);

    // 6: reset mid-frame discards the accumulated maximum
    accept(150);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    expect_lvl("rst", 0, 0);
    frame();
    expect_lvl("rst_frame", 0, 0);
    check("rst_ovl", int'(overload), 0);

    // random frames
    for (int f = 0; f < 200; f++) begin
      int hi = $urandom_range(25, 3);
      int lo = $urandom_range(4, 1);
      for (int c = 0; c < hi + lo; c++) begin
        int r = $urandom_range(7, 0);
        v_sync = (c < hi);
        sample_valid = $urandom_range(1, 0) == 1;
        if (r == 0)      sample_data = 8'hFF;
        else if (r == 1) sample_data = DW'($urandom_range(3, 0));
        else             sample_data = DW'($urandom_range(255, 0));
        if (c == 2 && $urandom_range(39, 0) == 0) reset = 1'b1;
        else reset = 1'b0;
        tick();
      end
    end
    reset = 1'b0;
    sample_valid = 1'b0;
    v_sync = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
